combination_lock_param: RTL and testbench

// - Parametrised successor to the digit-entry lock: N-digit code, per-press edge detect, reprogrammable code,

---
 rtl/combo_lock_pkg.sv | 32 +++
 rtl/seg7_scan.sv | 39 +++
 rtl/combination_lock_param.sv | 165 ++++++++++++++++
 tb/tb_combination_lock_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and seven-segment glyph constants for the parametrised combination lock.
// Glyphs are {dp,g,f,e,d,c,b,a}, active-low, decimal point always off.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    OPEN,
    PROG,
    ERROR,
    LOCKOUT
  } state_t;

  // Hex digits 0..F, index 15 first so HEX_GLYPHS[v] is the glyph for v
  localparam logic [15:0][7:0] HEX_GLYPHS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_N     = 8'hAB;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    return HEX_GLYPHS[v];
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: steps one slot every SCAN_DIV clocks,
// visiting digit 3, 2, 1, 0 and wrapping. Outputs are registered.
module seg7_scan
  import combo_lock_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0][7:0] glyphs,
  output logic [7:0]     data,
  output logic [3:0]     enable
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       slot;

  // Slot timer, slot rotation and registered glyph/select for the current slot
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= 2'd0;
      data    <= SEG_BLANK;
      enable  <= 4'b1110;
    end else begin
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        slot    <= slot - 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      enable <= ~(4'b0001 << slot);
      data   <= glyphs[slot];
    end
  end

endmodule

// File: rtl/combination_lock_param.sv
// Parametrised N-digit combination lock with reprogrammable code and status display.
// Optional build macro COMBO_LOCK_LOCKOUT_EN adds the failed-attempt counter and LOCKOUT state.
module combination_lock_param
  import combo_lock_pkg::*;
#(
  parameter int                          DIGIT_W      = 4,
  parameter int                          CODE_LEN     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                          MAX_TRIES    = 3,
  parameter int                          LOCKOUT_CYC  = 1000,
  parameter int                          SCAN_DIV     = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] x,
  input  logic               enter,
  input  logic               lock,
  input  logic               prog,
  output logic               door_open,
  output logic [7:0]         seven_segment_data,
  output logic [3:0]         seven_segment_enable
);

  localparam int         CODE_W  = CODE_LEN * DIGIT_W;
  localparam int         ERR_CYC = 8 * SCAN_DIV;
  localparam int         TMR_MAX = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
  localparam int         TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [3:0] FULL    = 4'(CODE_LEN);
  localparam logic [3:0] LAST    = 4'(CODE_LEN - 1);

  state_t            state, next_state;
  logic              enter_q, press;
  logic [CODE_W-1:0] entry, code, shifted;
  logic [3:0]        digit_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [3:0][7:0]   glyphs;

  assign shifted = (entry << DIGIT_W) | CODE_W'(x);

`ifdef COMBO_LOCK_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  logic [FAIL_W-1:0] fail_cnt;

  // Consecutive failures: cleared on a match or when lockout ends, saturating otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (state == LOCKED && digit_cnt == FULL) begin
      if (entry == code) begin
        fail_cnt <= '0;
      end else if (fail_cnt != FAIL_W'(MAX_TRIES)) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end else if (state == LOCKOUT && next_state == LOCKED) begin
      fail_cnt <= '0;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOCKED;
    else     state <= next_state;
  end

  // Next-state logic; the compare happens the cycle after the final digit lands
  always_comb begin
    next_state = state;
    case (state)
      LOCKED: begin
        if (digit_cnt == FULL) next_state = (entry == code) ? OPEN : ERROR;
      end
      OPEN: begin
        if (lock)      next_state = LOCKED;
        else if (prog) next_state = PROG;
      end
      PROG: begin
        if (lock)                            next_state = LOCKED;
        else if (press && digit_cnt == LAST) next_state = OPEN;
      end
      ERROR: begin
        if (tmr == TMR_W'(ERR_CYC - 1)) begin
`ifdef COMBO_LOCK_LOCKOUT_EN
          next_state = (fail_cnt == FAIL_W'(MAX_TRIES)) ? LOCKOUT : LOCKED;
`else
          next_state = LOCKED;
`endif
        end
      end
`ifdef COMBO_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr == TMR_W'(LOCKOUT_CYC - 1)) next_state = LOCKED;
      end
`endif
      default: next_state = LOCKED;
    endcase
  end

  // Press edge detect, digit entry, code programming, dwell timer and registered door output
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_q   <= 1'b0;
      press     <= 1'b0;
      entry     <= '0;
      code      <= DEFAULT_CODE;
      digit_cnt <= '0;
      tmr       <= '0;
      door_open <= 1'b0;
    end else begin
      enter_q   <= enter;
      press     <= enter & ~enter_q;
      door_open <= (next_state == OPEN) || (next_state == PROG);
      if (next_state != state)                   tmr <= '0;
      else if (state == ERROR || state == LOCKOUT) tmr <= tmr + 1'b1;
      else                                       tmr <= '0;
      case (state)
        LOCKED: begin
          if (digit_cnt == FULL) begin
            digit_cnt <= '0;
          end else if (press) begin
            entry     <= shifted;
            digit_cnt <= digit_cnt + 4'd1;
          end
        end
        PROG: begin
          if (lock) begin
            digit_cnt <= '0;
          end else if (press) begin
            if (digit_cnt == LAST) begin
              code      <= shifted;
              digit_cnt <= '0;
            end else begin
              entry     <= shifted;
              digit_cnt <= digit_cnt + 4'd1;
            end
          end
        end
        default: digit_cnt <= '0;
      endcase
    end
  end

  // Status text per state, digit 3 is the leftmost glyph
  always_comb begin
    glyphs = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
    case (state)
      LOCKED:  glyphs = {SEG_L, SEG_BLANK, SEG_BLANK, hex_glyph(digit_cnt)};
      OPEN:    glyphs = {SEG_O, SEG_P, SEG_E, SEG_N};
      PROG:    glyphs = {SEG_P, SEG_BLANK, SEG_BLANK, hex_glyph(digit_cnt)};
      ERROR:   glyphs = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
      default: glyphs = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
    endcase
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .glyphs (glyphs),
    .data   (seven_segment_data),
    .enable (seven_segment_enable)
  );

endmodule

// File: tb/tb_combination_lock_param.sv
// Directed self-checking bench for combination_lock_param (SCAN_DIV=4, LOCKOUT_CYC=20).
// The lockout scenario is compiled in when COMBO_LOCK_LOCKOUT_EN is defined.
module tb_combination_lock_param;

  localparam logic [7:0] G_L = 8'hC7, G_O = 8'hC0, G_P = 8'h8C, G_E = 8'h86;
  localparam logic [7:0] G_R = 8'hAF, G_N = 8'hAB, G_DASH = 8'hBF, G_BLANK = 8'hFF;
  localparam logic [7:0] G_0 = 8'hC0, G_1 = 8'hF9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] x = 4'd0;
  logic       enter = 1'b0;
  logic       lock = 1'b0;
  logic       prog = 1'b0;
  logic       door_open;
  logic [7:0] seven_segment_data;
  logic [3:0] seven_segment_enable;

  int checkCount = 0;
  int passCount = 0;

  combination_lock_param #(
    .SCAN_DIV(4),
    .LOCKOUT_CYC(20)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .x                    (x),
    .enter                (enter),
    .lock                 (lock),
    .prog                 (prog),
    .door_open            (door_open),
    .seven_segment_data   (seven_segment_data),
    .seven_segment_enable (seven_segment_enable)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    checkCount++;
    if (got !== want) $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    else passCount++;
  endtask

  // One digit press: enter high for one clock, then low for one
  task automatic applyStimulus(input logic [3:0] d);
    @(negedge clk);
    x = d;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic enterCode(input logic [15:0] c);
    applyStimulus(c[15:12]);
    applyStimulus(c[11:8]);
    applyStimulus(c[7:4]);
    applyStimulus(c[3:0]);
  endtask

  // Wait (bounded) for a digit slot to be selected, then check its glyph
  task automatic checkDigit(input string tag, input int slot, input logic [7:0] want);
    logic [3:0] sel;
    logic [7:0] seg;
    bit         seen;
    sel  = ~(4'b0001 << slot);
    seg  = 8'hxx;
    seen = 0;
    @(negedge clk);
    for (int i = 0; i < 24 && !seen; i++) begin
      if (seven_segment_enable == sel) begin
        seg  = seven_segment_data;
        seen = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) $display("[TB] digit %0d select not seen within bound", slot);
    checkOutput(tag, seg, want);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset door_open", {7'd0, door_open}, 8'h00);
    checkOutput("reset enable", {4'd0, seven_segment_enable}, 8'h0E);
    checkOutput("reset data", seven_segment_data, G_BLANK);
    rst = 1'b0;
    checkDigit("idle digit3 L", 3, G_L);
    checkDigit("idle digit0 cnt0", 0, G_0);

    // Held enter counts once
    @(negedge clk);
    x = 4'd1;
    enter = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    checkDigit("held enter cnt1", 0, G_1);
    checkDigit("held enter still L", 3, G_L);

    // Complete 1,2,3,4 and check door timing
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    checkOutput("door one clk early", {7'd0, door_open}, 8'h00);
    @(negedge clk);
    checkOutput("door open on time", {7'd0, door_open}, 8'h01);
    checkDigit("open digit3 O", 3, G_O);
    checkDigit("open digit2 P", 2, G_P);
    checkDigit("open digit1 E", 1, G_E);
    checkDigit("open digit0 n", 0, G_N);
    applyStimulus(4'd5);
    checkOutput("press in open ignored", {7'd0, door_open}, 8'h01);

    // Relock
    @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    checkOutput("lock closes door", {7'd0, door_open}, 8'h00);
    checkDigit("relocked digit3 L", 3, G_L);

    // Wrong code
    enterCode(16'h1235);
    @(negedge clk);
    checkOutput("wrong code door", {7'd0, door_open}, 8'h00);
    checkDigit("error digit3 E", 3, G_E);
    checkDigit("error digit2 r", 2, G_R);
    repeat (40) @(negedge clk);
    checkDigit("after error L", 3, G_L);
    checkDigit("after error cnt0", 0, G_0);

    // Reprogram to 9876
    enterCode(16'h1234);
    @(negedge clk);
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    checkOutput("prog door", {7'd0, door_open}, 8'h01);
    checkDigit("prog digit3 P", 3, G_P);
    enterCode(16'h9876);
    checkDigit("programmed back to OPEn", 3, G_O);
    @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("old code rejected", {7'd0, door_open}, 8'h00);
    repeat (40) @(negedge clk);
    enterCode(16'h9876);
    @(negedge clk);
    checkOutput("new code opens", {7'd0, door_open}, 8'h01);

    // Reset restores the default code
    pulseReset();
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("default code after rst", {7'd0, door_open}, 8'h01);
    @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;

    // Reset mid-entry
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid rst door", {7'd0, door_open}, 8'h00);
    checkOutput("mid rst enable", {4'd0, seven_segment_enable}, 8'h0E);
    checkOutput("mid rst data", seven_segment_data, G_BLANK);
    rst = 1'b0;
    checkDigit("mid rst cnt0", 0, G_0);

`ifdef COMBO_LOCK_LOCKOUT_EN
    // Three failures lead to lockout display
    for (int i = 0; i < 3; i++) begin
      enterCode(16'h5555);
      if (i < 2) repeat (40) @(negedge clk);
    end
    repeat (33) @(negedge clk);
    checkDigit("lockout dashes", 3, G_DASH);
    repeat (25) @(negedge clk);

    // Second lockout: presses during it are ignored
    for (int i = 0; i < 3; i++) begin
      enterCode(16'h5555);
      if (i < 2) repeat (40) @(negedge clk);
    end
    repeat (33) @(negedge clk);
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("lockout ignores code", {7'd0, door_open}, 8'h00);
    repeat (12) @(negedge clk);
    checkDigit("post lockout cnt0", 0, G_0);
    checkDigit("post lockout L", 3, G_L);
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("post lockout opens", {7'd0, door_open}, 8'h01);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
